// File: rtl/neuron_argmax_collector.sv
// neuron_argmax_collector
//   Collects one frame of NUM_CLASSES signed Q20.20 activations over a
//   valid/ready handshake. Each word is requantized to Q10.10 (round half up,
//   saturate). The block tracks the frame maximum and presents its class
//   index and value until the consumer accepts it.
//
//   Optional build macro: NEURON_ARGMAX_RELU_EN clamps negative requantized
//   values to 0 before they are compared and output.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   activation word available
//   in_ready   block accepts a word this cycle (registered)
//   in_data    signed Q20.20 activation, IN_W bits
//   out_valid  frame result available (registered)
//   out_ready  consumer accepts the result
//   out_class  index of the frame maximum
//   out_value  requantized maximum, Q10.10, DW bits
//   out_sat    at least one word of the frame saturated
module neuron_argmax_collector #(
  parameter int NUM_CLASSES = 10,
  parameter int IN_W        = 40,
  parameter int DW          = 20,
  parameter int FRAC_BITS   = 10,
  parameter int CLS_W       = $clog2(NUM_CLASSES)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CLS_W-1:0] out_class,
  output logic [DW-1:0]    out_value,
  output logic             out_sat
);

  typedef enum logic {ACCUM, DONE} state_t;

  // Rounding constant and clamp limits, all at the widened IN_W+1 width.
  localparam logic signed [IN_W:0] RND =
    {{(IN_W+1-FRAC_BITS){1'b0}}, 1'b1, {(FRAC_BITS-1){1'b0}}};
  localparam logic signed [IN_W:0] QMAX =
    {{(IN_W+2-DW){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [IN_W:0] QMIN =
    {{(IN_W+2-DW){1'b1}}, {(DW-1){1'b0}}};
  localparam logic [CLS_W-1:0] LAST = CLS_W'(NUM_CLASSES - 1);

  state_t           state;
  logic [CLS_W-1:0] idx;

  logic signed [IN_W:0]   ext;
  logic signed [IN_W:0]   sh;
  logic signed [DW-1:0]   q;
  logic                   sat_w;
  logic                   accept;

  assign accept = in_valid && in_ready;

  // Requantize the incoming word: widen by one bit so the rounding add cannot
  // overflow, shift arithmetically, then clamp to the DW-bit range.
  always_comb begin
    ext   = $signed({in_data[IN_W-1], in_data}) + RND;
    sh    = ext >>> FRAC_BITS;
    q     = sh[DW-1:0];
    sat_w = 1'b0;
    if (sh > QMAX) begin
      q     = QMAX[DW-1:0];
      sat_w = 1'b1;
    end else if (sh < QMIN) begin
      q     = QMIN[DW-1:0];
      sat_w = 1'b1;
    end
`ifdef NEURON_ARGMAX_RELU_EN
    if (q[DW-1]) q = '0;
`endif
  end

  // out_class/out_value/out_sat double as the running best/sat trackers; they
  // are only meaningful to the consumer while out_valid is high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ACCUM;
      idx       <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_class <= '0;
      out_value <= '0;
      out_sat   <= 1'b0;
    end else begin
      case (state)
        ACCUM: begin
          if (accept) begin
            if (idx == '0) begin
              out_value <= q;
              out_class <= '0;
              out_sat   <= sat_w;
            end else begin
              if (q > $signed(out_value)) begin
                out_value <= q;
                out_class <= idx;
              end
              out_sat <= out_sat | sat_w;
            end
            if (idx == LAST) begin
              idx       <= '0;
              state     <= DONE;
              in_ready  <= 1'b0;
              out_valid <= 1'b1;
            end else begin
              idx <= idx + CLS_W'(1);
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= ACCUM;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            idx       <= '0;
            out_class <= '0;
            out_value <= '0;
            out_sat   <= 1'b0;
          end
        end
        default: begin
          state     <= ACCUM;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          idx       <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_neuron_argmax_collector.sv
// tb_neuron_argmax_collector
//   Table of directed frames, hand-written backpressure and mid-frame reset
//   sequences, and random frames checked against an arithmetic reference.
module tb_neuron_argmax_collector;

  localparam int N  = 10;
  localparam int IW = 40;
  localparam int DW = 20;
  localparam int CW = $clog2(N);
  localparam longint M = 64'sd1 << 20;

  typedef longint frame_t [N];
  typedef struct {
    frame_t d;
    int     cls;
    longint val;
    bit     sat;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [IW-1:0] in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [CW-1:0] out_class;
  logic [DW-1:0] out_value;
  logic          out_sat;

  int total = 0;
  int bad   = 0;

  neuron_argmax_collector #(
    .NUM_CLASSES(N),
    .IN_W(IW),
    .DW(DW),
    .FRAC_BITS(10)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_class(out_class),
    .out_value(out_value),
    .out_sat(out_sat)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: requantize each word with plain integer arithmetic, then scan
  // for the first maximum.
  function automatic longint requant(input longint x, output bit s);
    longint r;
    r = (x + 512) >>> 10;
    s = 1'b0;
    if (r > 524287) begin r = 524287; s = 1'b1; end
    if (r < -524288) begin r = -524288; s = 1'b1; end
`ifdef NEURON_ARGMAX_RELU_EN
    if (r < 0) r = 0;
`endif
    return r;
  endfunction

  task automatic model(input frame_t d, output int cls, output longint val, output bit sat);
    longint v;
    bit s;
    sat = 1'b0;
    cls = 0;
    val = 0;
    for (int i = 0; i < N; i++) begin
      v = requant(d[i], s);
      sat |= s;
      if (i == 0 || v > val) begin
        val = v;
        cls = i;
      end
    end
  endtask

  // Called at a negedge; returns at the negedge after the word was accepted.
  task automatic send_word(input longint x);
    int n;
    in_valid = 1'b1;
    in_data  = x[IW-1:0];
    n = 0;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      $display("FAIL send_word: in_ready got 0 expected 1 within budget");
      bad++;
      total++;
    end
    @(negedge clk);
  endtask

  task automatic send_frame(input frame_t d);
    for (int i = 0; i < N; i++) send_word(d[i]);
    in_valid = 1'b0;
  endtask

  task automatic check_result(input string name, input int cls, input longint val, input bit sat);
    check({name, " out_valid"}, longint'(out_valid), 1);
    check({name, " class"}, longint'(out_class), longint'(cls));
    check({name, " value"}, longint'($signed(out_value)), val);
    check({name, " sat"}, longint'(out_sat), longint'(sat));
  endtask

  task automatic collect();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("after handshake out_valid", longint'(out_valid), 0);
  endtask

  vec_t   tbl [8];
  frame_t fr;
  int     mc;
  longint mv;
  bit     ms;

  initial begin
    // Directed table.
    for (int t = 0; t < 8; t++) for (int i = 0; i < N; i++) tbl[t].d[i] = 0;
    tbl[0].d[0] = M;                     tbl[0].cls = 0; tbl[0].val = 1024;  tbl[0].sat = 0;
    tbl[1].d[0] = M + 511;               tbl[1].cls = 0; tbl[1].val = 1024;  tbl[1].sat = 0;
    tbl[2].d[0] = M + 512;               tbl[2].cls = 0; tbl[2].val = 1025;  tbl[2].sat = 0;
    for (int i = 1; i < N; i++) tbl[3].d[i] = -5 * M;
    tbl[3].d[0] = -1536;                 tbl[3].cls = 0;                     tbl[3].sat = 0;
`ifdef NEURON_ARGMAX_RELU_EN
    tbl[3].val = 0;
`else
    tbl[3].val = -1;
`endif
    tbl[4].d[3] = M + 512;               tbl[4].cls = 3; tbl[4].val = 1025;  tbl[4].sat = 0;
    for (int i = 0; i < N; i++) tbl[5].d[i] = i * M;
    tbl[5].d[2] = 20 * M; tbl[5].d[5] = 20 * M;
    tbl[5].cls = 2; tbl[5].val = 20480; tbl[5].sat = 0;
    tbl[6].d[4] = 64'sd1 << 35; tbl[6].d[6] = -(64'sd1 << 35);
    tbl[6].cls = 4; tbl[6].val = 524287; tbl[6].sat = 1;
    for (int i = 0; i < N; i++) tbl[7].d[i] = -(i + 1) * M;
    tbl[7].cls = 0; tbl[7].sat = 0;
`ifdef NEURON_ARGMAX_RELU_EN
    tbl[7].val = 0;
`else
    tbl[7].val = -1024;
`endif

    repeat (2) @(negedge clk);
    check("reset in_ready", longint'(in_ready), 1);
    check("reset out_valid", longint'(out_valid), 0);
    check("reset out_class", longint'(out_class), 0);
    check("reset out_value", longint'(out_value), 0);
    check("reset out_sat", longint'(out_sat), 0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int t = 0; t < 8; t++) begin
      send_frame(tbl[t].d);
      check_result($sformatf("tbl%0d", t), tbl[t].cls, tbl[t].val, tbl[t].sat);
      collect();
    end

    // Backpressure: result held while the next frame's first word waits.
    send_frame(tbl[5].d);
    in_valid = 1'b1;
    in_data  = tbl[4].d[0][IW-1:0];
    for (int c = 0; c < 5; c++) begin
      check("bp in_ready", longint'(in_ready), 0);
      check_result("bp hold", 2, 20480, 0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("bp out_valid dropped", longint'(out_valid), 0);
    check("bp in_ready back", longint'(in_ready), 1);
    send_frame(tbl[4].d);
    check_result("bp next frame", 3, 1025, 0);
    collect();

    // Reset mid-frame discards the partial maximum.
    send_word(M);
    send_word(100 * M);
    send_word(2 * M);
    send_word(3 * M);
    rst_n = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check("midreset out_value", longint'(out_value), 0);
    check("midreset in_ready", longint'(in_ready), 1);
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < N; i++) fr[i] = M;
    send_frame(fr);
    check_result("after reset", 0, 1024, 0);
    collect();

    // Random frames against the reference.
    for (int r = 0; r < 30; r++) begin
      for (int i = 0; i < N; i++) begin
        case ($urandom_range(3))
          0: fr[i] = longint'($urandom_range(0, 1 << 23)) - (64'sd1 << 22);
          1: fr[i] = (longint'($urandom) << 8) - (64'sd1 << 39);
          2: fr[i] = (i > 0) ? fr[i-1] : 0;
          default: fr[i] = longint'($urandom_range(0, 4095)) * 1024 - 2048 * 1024 + longint'($urandom_range(0, 1023));
        endcase
      end
      model(fr, mc, mv, ms);
      send_frame(fr);
      if ($urandom_range(1)) repeat ($urandom_range(1, 3)) @(negedge clk);
      check_result($sformatf("rand%0d", r), mc, mv, ms);
      collect();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/neuron_argmax_collector.md
Name: neuron_argmax_collector

Overview:
- Downstream stage of the two-input neuron. Consumes its 40-bit signed Q20.20 `activation` results, one per output neuron, over a valid/ready handshake.
- Requantizes each result to the 20-bit Q10.10 datapath format with rounding and saturation.
- Tracks the running maximum over one frame of NUM_CLASSES results, then presents the winning class index and value to the consumer.

Parameters:
- NUM_CLASSES, 10, activations per frame; must be >= 2.
- IN_W, 40, input activation width, signed two's complement.
- DW, 20, output value width, signed two's complement.
- FRAC_BITS, 10, right-shift applied in requantization; matches the Q10.10 fractional bits.
- CLS_W, $clog2(NUM_CLASSES), class index width.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  activation word available
- in_ready  output  1  block accepts a word this cycle
- in_data  input  IN_W  signed Q20.20 activation from the neuron
- out_valid  output  1  frame result available
- out_ready  input  1  consumer accepts the result
- out_class  output  CLS_W  index of the maximum activation in the frame
- out_value  output  DW  requantized maximum value, Q10.10
- out_sat  output  1  at least one word in the frame saturated

Behaviour:
- Single clock domain; rst_n is asynchronous and active-low; all state is cleared on assertion.
- Reset values:
  - in_ready = 1, out_valid = 0, out_class = 0, out_value = 0, out_sat = 0.
  - Index counter = 0, state = ACCUM.
- FSM states: ACCUM, DONE.
- ACCUM:
  - in_ready = 1.
  - Accept occurs when in_valid && in_ready.
  - On accept at index k, k advances; on the accept where k = NUM_CLASSES-1 the FSM goes to DONE.
- DONE:
  - in_ready = 0, out_valid = 1, outputs held stable.
  - On out_valid && out_ready, next cycle: out_valid = 0, state = ACCUM, index = 0, best/sat trackers cleared.
  - The next frame's first word is accepted no earlier than the cycle after the handshake.
- Latency: out_valid rises on the clock edge that accepts the last word (registered); it is high the cycle after the last accept.
- Requantization per word:
  - Sign-extend in_data to IN_W+1 bits and add 2^(FRAC_BITS-1), giving round-half-up toward +inf.
  - Arithmetic shift right by FRAC_BITS.
  - If the result exceeds 2^(DW-1)-1, clamp to 2^(DW-1)-1 and set sat; if it is below -2^(DW-1), clamp to -2^(DW-1) and set sat.
- Argmax:
  - Index 0 loads best value and class unconditionally.
  - Later indices replace best only if q > best (strict), so ties keep the lowest index.
  - The comparison uses the requantized value.
- out_sat is the OR of saturation flags across the frame's words.
- in_data is ignored when in_valid is low or in DONE; in_valid asserted in DONE is not accepted and the word must be held by the producer.
- If out_ready is already high when DONE is entered, the handshake completes the first cycle out_valid is high.
- Asserting rst_n low mid-frame discards partial results; no output is produced for that frame.

Optional Feature:
- Macro: NEURON_ARGMAX_RELU_EN.
- Defined: after requantization and saturation, negative values are clamped to 0 before comparison and output. out_value is never negative; an all-negative frame returns class 0, value 0.
- Undefined: signed values are compared directly; an all-negative frame returns the least-negative entry.

Test Plan:
- Requant/rounding:
  - Single frame with index 0 = 2^20 → 1024.
  - 2^20+511 → 1024; 2^20+512 → 1025; -1536 → -1.
  - Place 2^20+512 at index 3 with all others at 0 → out_class = 3, out_value = 1025, out_sat = 0.
- Argmax + ties: inputs k·2^20 for k = 0..9, except indices 2 and 5 = 20·2^20 → out_class = 2, out_value = 20480.
- Saturation: index 4 = 2^35, index 6 = -2^35, rest 0 → out_class = 4, out_value = 524287, out_sat = 1.
- Backpressure: hold out_ready = 0 for 5 cycles with in_valid = 1 → in_ready = 0 and outputs stable throughout. Then out_ready = 1 for 1 cycle → out_valid drops next cycle, and the next frame's first word is accepted the cycle after.
- Reset mid-frame: accept 4 words including a 100·2^20 maximum, pulse rst_n low, then send a full frame of all 2^20 → out_class = 0, out_value = 1024; no stale maximum.
- All-negative frame (-(k+1)·2^20):
  - NEURON_ARGMAX_RELU_EN undefined → out_class = 0, out_value = -1024.
  - NEURON_ARGMAX_RELU_EN defined → out_class = 0, out_value = 0.
